// File: rtl/bcd_down_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_down_timer
//  Purpose  : Loadable multi-digit BCD down-counter/timer with start/stop,
//             count-enable gating, optional auto-reload, terminal-count pulse
//             and rejected-load error pulse. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_down_timer #(
   parameter int DIGITS = 2                    // legal range 1..8
) (
   input  logic                  clk,
   input  logic                  rst,          // asynchronous, active-high
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  en,
   input  logic                  reload_en,
   output logic [4*DIGITS-1:0]   count,
   output logic                  busy,
   output logic                  zero,
   output logic                  tc,
   output logic                  err
);

   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t          state;
   logic [W-1:0]    rld;           // last accepted load value, used on reload
   logic [W-1:0]    dec_val;       // count minus one, BCD-correct
   logic [DIGITS-1:0] digit_ok;    // per-digit validity of load_val
   logic [DIGITS-1:0] borrow;      // borrow into each digit of the decrement
   logic            load_ok;
   logic            count_is_one;
   logic            count_is_zero;

   // Per-digit load validation and rippling BCD decrement.
   // Digit 0 always receives a borrow; a digit at 0 wraps to 9 and passes
   // the borrow upward, so the whole chain settles in one cycle.
   assign borrow[0] = 1'b1;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         logic [3:0] cur;
         assign cur          = count[4*i +: 4];
         assign digit_ok[i]  = (load_val[4*i +: 4] <= 4'd9);
         assign dec_val[4*i +: 4] = !borrow[i]      ? cur  :
                                    (cur == 4'd0)   ? 4'd9 :
                                                      cur - 4'd1;
         if (i < DIGITS - 1) begin : g_borrow
            assign borrow[i+1] = borrow[i] & (cur == 4'd0);
         end
      end
   endgenerate

   assign load_ok       = &digit_ok;
   assign count_is_one  = (count == ONE);
   assign count_is_zero = (count == '0);

   // Control FSM and datapath; priority is load, stop, start, decrement.
   // busy and zero are written alongside state and count so that every
   // output is a register and all of them agree on each edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         count <= '0;
         rld   <= '0;
         busy  <= 1'b0;
         zero  <= 1'b1;
         tc    <= 1'b0;
         err   <= 1'b0;
      end else begin
         tc  <= 1'b0;
         err <= 1'b0;
         if (load && load_ok) begin
            // Accepted load overrides start/stop/decrement this cycle.
            count <= load_val;
            rld   <= load_val;
            zero  <= (load_val == '0);
            if ((state == S_RUN) && (load_val == '0)) begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         end else begin
            // A rejected load only flags the error; the rest still applies.
            if (load) begin
               err <= 1'b1;
            end
            case (state)
               S_RUN: begin
                  if (stop) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else if (en && !count_is_zero) begin
                     if (count_is_one) begin
                        tc <= 1'b1;
                        if (reload_en) begin
                           count <= rld;
                           zero  <= (rld == '0);
                        end else begin
                           count <= '0;
                           zero  <= 1'b1;
                           state <= S_IDLE;
                           busy  <= 1'b0;
                        end
                     end else begin
                        count <= dec_val;
                        zero  <= 1'b0;
                     end
                  end
               end
               default: begin
                  if (start && !count_is_zero) begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bcd_down_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_down_timer
//  Purpose  : Self-checking bench for bcd_down_timer (DIGITS=2). A driver
//             applies directed and random stimulus, a decimal reference model
//             pushes expected outputs into a queue, and a monitor compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_down_timer;

   localparam int D = 2;
   localparam int W = 4 * D;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         en = 1'b0;
   logic         reload_en = 1'b0;
   logic [W-1:0] count;
   logic         busy;
   logic         zero;
   logic         tc;
   logic         err;

   bcd_down_timer #(.DIGITS(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_val  (load_val),
      .start     (start),
      .stop      (stop),
      .en        (en),
      .reload_en (reload_en),
      .count     (count),
      .busy      (busy),
      .zero      (zero),
      .tc        (tc),
      .err       (err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model state: plain decimal integers.
   int m_cnt = 0;
   int m_rld = 0;
   bit m_run = 1'b0;

   // Expected packed as {count, busy, zero, tc, err}.
   logic [W+3:0] exp_q[$];

   function automatic bit is_bcd(input logic [W-1:0] v);
      for (int i = 0; i < D; i++)
         if (v[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int bcd2int(input logic [W-1:0] v);
      int r = 0;
      for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int n);
      logic [W-1:0] r = '0;
      int k = n;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(k % 10);
         k = k / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // One clock of stimulus: drive at the falling edge, predict the result of
   // the next rising edge from the timer rules, queue the prediction.
   task automatic cyc(input logic l, input logic [W-1:0] v, input logic sp,
                      input logic st, input logic e, input logic r);
      bit t_tc = 1'b0;
      bit t_err = 1'b0;
      @(negedge clk);
      load = l; load_val = v; stop = sp; start = st; en = e; reload_en = r;
      if (l && is_bcd(v)) begin
         m_cnt = bcd2int(v);
         m_rld = m_cnt;
         if (m_run && m_cnt == 0) m_run = 1'b0;
      end else begin
         if (l) t_err = 1'b1;
         if (m_run) begin
            if (sp) m_run = 1'b0;
            else if (e) begin
               if (m_cnt == 1) begin
                  t_tc = 1'b1;
                  if (r) m_cnt = m_rld;
                  else begin m_cnt = 0; m_run = 1'b0; end
               end else begin
                  m_cnt = m_cnt - 1;
               end
            end
         end else if (st && m_cnt != 0) begin
            m_run = 1'b1;
         end
      end
      exp_q.push_back({int2bcd(m_cnt), m_run, (m_cnt == 0), t_tc, t_err});
   endtask

   // Wait until the most recently queued cycle has been sampled.
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Asynchronous reset between edges, checked without waiting for a clock.
   task automatic apply_reset();
      @(negedge clk);
      load = 0; load_val = '0; stop = 0; start = 0; en = 0; reload_en = 0;
      #2 rst = 1'b1;
      #1;
      chk("rst_count", count, '0);
      chk("rst_busy",  W'(busy), '0);
      chk("rst_zero",  W'(zero), W'(1));
      chk("rst_tc",    W'(tc), '0);
      chk("rst_err",   W'(err), '0);
      m_cnt = 0; m_rld = 0; m_run = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every sampled cycle with a pending prediction is compared.
   initial begin
      logic [W+3:0] got;
      logic [W+3:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            got = {count, busy, zero, tc, err};
            e = exp_q.pop_front();
            tests++;
            if (got !== e) begin
               fails++;
               $display("FAIL cycle_check: got count=%h busy=%b zero=%b tc=%b err=%b, expected count=%h busy=%b zero=%b tc=%b err=%b at %0t",
                        got[W+3:4], got[3], got[2], got[1], got[0],
                        e[W+3:4], e[3], e[2], e[1], e[0], $time);
            end
         end
      end
   end

   // Watchdog so the bench always ends on its own.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      logic         l, sp, st, e, r;
      logic [W-1:0] v;

      // Power-on reset.
      @(negedge clk);
      chk("por_count", count, '0);
      chk("por_zero",  W'(zero), W'(1));
      chk("por_busy",  W'(busy), '0);
      rst = 1'b0;

      // Start with count 0 is ignored.
      cyc(0, '0, 0, 1, 1, 0);
      cyc(0, '0, 0, 0, 1, 0);

      // Basic countdown from 25 through the 20->19 borrow to 0.
      cyc(1, 8'h25, 0, 0, 0, 0);
      cyc(0, '0, 0, 1, 0, 0);
      for (int i = 0; i < 25; i++) cyc(0, '0, 0, 0, 1, 0);
      settle();
      chk("basic_end_count", count, 8'h00);
      chk("basic_end_tc",    W'(tc), W'(1));
      chk("basic_end_busy",  W'(busy), '0);
      cyc(0, '0, 0, 0, 1, 0);

      // Reset asserted in the middle of a run.
      cyc(1, 8'h40, 0, 0, 0, 0);
      cyc(0, '0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0, 1, 0);
      apply_reset();
      cyc(0, '0, 0, 1, 1, 0);
      cyc(0, '0, 0, 0, 1, 0);

      // Auto-reload: 03,02,01,03,... never showing zero.
      cyc(1, 8'h03, 0, 0, 0, 1);
      cyc(0, '0, 0, 1, 0, 1);
      for (int i = 0; i < 10; i++) cyc(0, '0, 0, 0, 1, 1);
      cyc(0, '0, 1, 0, 1, 1);

      // Gating and stop.
      cyc(1, 8'h15, 0, 0, 0, 0);
      cyc(0, '0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) cyc(0, '0, 0, 0, 0, 0);
      settle();
      chk("gate_hold", count, 8'h12);
      cyc(0, '0, 1, 0, 1, 0);
      settle();
      chk("stop_busy",  W'(busy), '0);
      chk("stop_count", count, 8'h12);
      cyc(0, '0, 0, 1, 1, 0);
      cyc(0, '0, 0, 0, 1, 0);
      settle();
      chk("resume_count", count, 8'h11);

      // Invalid load keeps count and reload value.
      cyc(1, 8'h07, 0, 0, 0, 1);
      cyc(1, 8'h3A, 0, 0, 0, 1);
      settle();
      chk("inv_err",   W'(err), W'(1));
      chk("inv_count", count, 8'h07);
      cyc(0, '0, 0, 1, 0, 1);
      for (int i = 0; i < 9; i++) cyc(0, '0, 0, 0, 1, 1);
      cyc(1, 8'hA0, 1, 0, 0, 1);

      // Simultaneous load with a pending terminal count, then load of 0 in RUN.
      cyc(1, 8'h02, 0, 0, 0, 0);
      cyc(0, '0, 0, 1, 0, 0);
      cyc(0, '0, 0, 0, 1, 0);
      cyc(1, 8'h50, 0, 0, 1, 0);
      settle();
      chk("sim_load_count", count, 8'h50);
      chk("sim_load_busy",  W'(busy), W'(1));
      cyc(1, 8'h00, 0, 0, 1, 0);
      settle();
      chk("load0_busy", W'(busy), '0);
      chk("load0_tc",   W'(tc), '0);

      // Randomized traffic.
      r = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         l  = ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 2))
            0:       v = int2bcd($urandom_range(0, 99));
            1:       v = int2bcd($urandom_range(0, 6));
            default: v = W'($urandom_range(0, 255));
         endcase
         sp = ($urandom_range(0, 19) == 0);
         st = ($urandom_range(0, 3) == 0);
         e  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 63) == 0) r = ~r;
         if ($urandom_range(0, 399) == 0) apply_reset();
         cyc(l, v, sp, st, e, r);
      end

      settle();
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d predictions unchecked, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
